// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issue/drain sequencer between EX and the shared multi-cycle divider
// Optional divide-by-zero shortcut: DIV_CTRL_ZERO_BYPASS_EN.
module div_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              div_clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_x,
  input  logic [DATA_W-1:0] req_y,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              dv_start,
  output logic              dv_signed,
  output logic [DATA_W-1:0] dv_x,
  output logic [DATA_W-1:0] dv_y,
  input  logic [DATA_W-1:0] dv_s,
  input  logic [DATA_W-1:0] dv_r,
  input  logic              dv_complete,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                signed_q, signed_d;
  logic                op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                accept;

  assign req_ready = resetn & (state_q == S_IDLE) & ~flush;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    signed_d   = signed_q;
    op_d       = op_q;
    tag_d      = tag_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d      = req_x;
          y_d      = req_y;
          signed_d = req_signed;
          op_d     = req_op;
          tag_d    = req_tag;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
          if (req_y == '0) begin
            rsp_data_d = req_op ? req_x : '1;
            state_d    = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: state_d = flush ? S_IDLE : S_WAIT;
      S_WAIT: begin
        // A completion that coincides with a flush is simply dropped; no drain needed.
        if (dv_complete) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            rsp_data_d = op_q ? dv_r : dv_s;
            state_d    = S_DONE;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (dv_complete) state_d = S_IDLE;
      S_DONE:  if (flush || rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      signed_q   <= 1'b0;
      op_q       <= 1'b0;
      tag_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      signed_q   <= signed_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign dv_start  = resetn & (state_q == S_ISSUE) & ~flush;
  assign dv_signed = signed_q;
  assign dv_x      = x_q;
  assign dv_y      = y_q;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = tag_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - scoreboard bench for div_issue_ctrl with a directed divider stub
module tb_div_issue_ctrl;
  logic        div_clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_signed, req_op;
  logic [31:0] req_x, req_y;
  logic [4:0]  req_tag;
  logic        flush;
  logic        dv_start, dv_signed;
  logic [31:0] dv_x, dv_y, dv_s, dv_r;
  logic        dv_complete;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  logic [36:0] exp_q[$];

  always #5 div_clk = ~div_clk;

  div_issue_ctrl #(.DATA_W(32), .TAG_W(5)) dut (
    .div_clk(div_clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .flush(flush),
    .dv_start(dv_start), .dv_signed(dv_signed), .dv_x(dv_x), .dv_y(dv_y),
    .dv_s(dv_s), .dv_r(dv_r), .dv_complete(dv_complete),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a response is delivered when valid & ready and no flush wins that cycle.
  always @(negedge div_clk) begin
    if (resetn && dv_start) start_cnt++;
    if (resetn && rsp_valid && rsp_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {27'd0, rsp_tag}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e[36:5]);
        check("rsp_tag", {27'd0, rsp_tag}, {27'd0, e[4:0]});
      end
    end
  end

  // Holds request inputs for one edge; caller guarantees the controller is idle.
  task automatic accept(input logic [31:0] x, input logic [31:0] y, input logic sg,
                        input logic op, input logic [4:0] tag);
    req_x = x; req_y = y; req_signed = sg; req_op = op; req_tag = tag; req_valid = 1'b1;
    @(negedge div_clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge div_clk); #1;
    req_valid = 1'b0;
  endtask

  // Called in the ISSUE cycle; plays the divider for lat cycles then completes.
  task automatic run_div(input int lat, input logic [31:0] x, input logic [31:0] y,
                         input logic sg, input logic [31:0] s, input logic [31:0] r);
    @(negedge div_clk);
    check("dv_start", {31'd0, dv_start}, 32'd1);
    check("dv_x", dv_x, x);
    check("dv_y", dv_y, y);
    check("dv_signed", {31'd0, dv_signed}, {31'd0, sg});
    @(posedge div_clk); #1;
    repeat (lat - 1) @(posedge div_clk);
    #1;
    dv_s = s; dv_r = r; dv_complete = 1'b1;
    @(posedge div_clk); #1;
    dv_complete = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b1; req_signed = 1'b0; req_op = 1'b0;
    req_x = 32'd5; req_y = 32'd1; req_tag = 5'd1; flush = 1'b0;
    dv_s = '0; dv_r = '0; dv_complete = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge div_clk);
    @(negedge div_clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dv_start", {31'd0, dv_start}, 32'd0);
    check("rst_dv_x", dv_x, 32'd0);
    req_valid = 1'b0;
    @(posedge div_clk); #1;
    resetn = 1'b1;
    @(negedge div_clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge div_clk); #1;

    // 1: unsigned 100/7 quotient
    exp_q.push_back({32'd14, 5'd3});
    accept(32'd100, 32'd7, 1'b0, 1'b0, 5'd3);
    run_div(4, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    @(posedge div_clk); #1;

    // 2: signed -7/2, remainder then quotient
    exp_q.push_back({32'hFFFF_FFFF, 5'd4});
    accept(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 5'd4);
    run_div(3, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    @(posedge div_clk); #1;
    exp_q.push_back({32'hFFFF_FFFD, 5'd5});
    accept(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 5'd5);
    run_div(3, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    @(posedge div_clk); #1;
    check("starts_after_t2", start_cnt, 32'd3);

    // 3: flush two cycles after dv_start drains the stale completion
    accept(32'd50, 32'd5, 1'b0, 1'b0, 5'd6);
    @(posedge div_clk); #1;
    @(posedge div_clk); #1;
    flush = 1'b1;
    @(posedge div_clk); #1;
    flush = 1'b0;
    @(negedge div_clk);
    check("drain_busy", {31'd0, busy}, 32'd1);
    check("drain_req_ready", {31'd0, req_ready}, 32'd0);
    check("drain_dv_x", dv_x, 32'd50);
    @(posedge div_clk); #1;
    dv_s = 32'd10; dv_r = 32'd0; dv_complete = 1'b1;
    @(posedge div_clk); #1;
    dv_complete = 1'b0;
    @(negedge div_clk);
    check("drain_done_busy", {31'd0, busy}, 32'd0);
    check("drain_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge div_clk); #1;
    exp_q.push_back({32'd3, 5'd7});
    accept(32'd9, 32'd3, 1'b0, 1'b0, 5'd7);
    run_div(3, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);
    @(posedge div_clk); #1;

    // 4: flush in the ISSUE cycle
    accept(32'd8, 32'd2, 1'b0, 1'b0, 5'd8);
    flush = 1'b1;
    @(negedge div_clk);
    check("issue_flush_no_start", {31'd0, dv_start}, 32'd0);
    @(posedge div_clk); #1;
    flush = 1'b0;
    @(negedge div_clk);
    check("issue_flush_idle", {31'd0, busy}, 32'd0);
    check("starts_after_t4", start_cnt, 32'd5);
    @(posedge div_clk); #1;

    // 5: back-pressure in DONE
    rsp_ready = 1'b0;
    exp_q.push_back({32'd5, 5'd9});
    accept(32'd20, 32'd4, 1'b0, 1'b0, 5'd9);
    run_div(2, 32'd20, 32'd4, 1'b0, 32'd5, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge div_clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_data", rsp_data, 32'd5);
      check("hold_tag", {27'd0, rsp_tag}, 32'd9);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge div_clk); #1;
    rsp_ready = 1'b1;
    @(posedge div_clk); #1;
    @(negedge div_clk);
    check("released_idle", {31'd0, busy}, 32'd0);
    @(posedge div_clk); #1;

    // 5b: flush and rsp_ready together in DONE -> not delivered
    rsp_ready = 1'b0;
    accept(32'd30, 32'd6, 1'b0, 1'b0, 5'd10);
    run_div(2, 32'd30, 32'd6, 1'b0, 32'd5, 32'd0);
    flush = 1'b1; rsp_ready = 1'b1;
    @(posedge div_clk); #1;
    flush = 1'b0;
    @(negedge div_clk);
    check("flush_done_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge div_clk); #1;

    // stray completion while IDLE is ignored
    dv_s = 32'hDEAD; dv_complete = 1'b1;
    @(posedge div_clk); #1;
    dv_complete = 1'b0;
    @(negedge div_clk);
    check("stray_busy", {31'd0, busy}, 32'd0);
    @(posedge div_clk); #1;

    // 6: divide by zero, remainder
`ifdef DIV_CTRL_ZERO_BYPASS_EN
    exp_q.push_back({32'h1234, 5'd11});
    accept(32'h1234, 32'd0, 1'b0, 1'b1, 5'd11);
    @(negedge div_clk);
    check("bypass_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge div_clk); #1;
    check("starts_final", start_cnt, 32'd7);
`else
    exp_q.push_back({32'h1234, 5'd11});
    accept(32'h1234, 32'd0, 1'b0, 1'b1, 5'd11);
    run_div(3, 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234);
    @(posedge div_clk); #1;
    check("starts_final", start_cnt, 32'd8);
`endif
    repeat (3) @(posedge div_clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
